control_unit: RTL and testbench

//  Multi-cycle control FSM for the K-and-S processor; sits directly upstream of data_path.

---
 rtl/k_and_s_pkg.sv | 119 +++++++++++
 rtl/control_unit_if.sv | 40 ++++
 rtl/branch_eval.sv | 38 +++
 rtl/control_unit.sv | 138 +++++++++++++
 tb/tb_control_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/k_and_s_pkg.sv
// +--------------------------------------------------------------------+
// | k_and_s_pkg : shared K-and-S types, control-unit states and ALU     |
// |               opcodes, plus the state-to-strobe decode function     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_BOV    = 4'd11,
    I_BNOV   = 4'd12,
    I_BNNEG  = 4'd13,
    I_BNZERO = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LOAD   = 4'd3,
    STORE  = 4'd4,
    ALU    = 4'd5,
    BRANCH = 4'd6,
    NOP    = 4'd7,
    HALT   = 4'd8
  } cu_state_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  localparam logic [1:0] OP_OR  = 2'b00;

  localparam int CU_CNT_W = 2;

  typedef struct packed {
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       addr_sel;
    logic       c_sel;
    logic [1:0] operation;
    logic       write_reg_enable;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic       halt;
  } cu_ctrl_t;

  function automatic cu_state_t cu_dispatch(input decoded_instruction_type instr);
    cu_state_t s;
    s = NOP;
    case (instr)
      I_LOAD:                                   s = LOAD;
      I_STORE:                                  s = STORE;
      I_MOVE, I_ADD, I_SUB, I_AND, I_OR:        s = ALU;
      I_BRANCH, I_BZERO, I_BNEG, I_BOV,
      I_BNOV, I_BNNEG, I_BNZERO:                s = BRANCH;
      I_HALT:                                   s = HALT;
      default:                                  s = NOP;
    endcase
    return s;
  endfunction

  // 'last' marks the final wait cycle of FETCH/LOAD.
  function automatic cu_ctrl_t cu_ctrl(input cu_state_t s, input logic last,
                                       input decoded_instruction_type instr,
                                       input logic taken);
    cu_ctrl_t c;
    c = '0;
    case (s)
      FETCH: c.ir_enable = last;
      LOAD: begin
        c.addr_sel         = 1'b1;
        c.write_reg_enable = last;
        c.pc_enable        = last;
      end
      STORE: begin
        c.addr_sel         = 1'b1;
        c.ram_write_enable = 1'b1;
        c.pc_enable        = 1'b1;
      end
      ALU: begin
        c.c_sel            = 1'b1;
        c.write_reg_enable = 1'b1;
        c.pc_enable        = 1'b1;
        c.flags_reg_enable = (instr != I_MOVE);
        case (instr)
          I_ADD:   c.operation = OP_ADD;
          I_SUB:   c.operation = OP_SUB;
          I_AND:   c.operation = OP_AND;
          default: c.operation = OP_OR;
        endcase
      end
      BRANCH: begin
        c.pc_enable = 1'b1;
        c.branch    = taken;
      end
      NOP:     c.pc_enable = 1'b1;
      HALT:    c.halt      = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// +--------------------------------------------------------------------+
// | control_unit_if : control_unit <-> data_path signal bundle          |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

interface control_unit_if;
  import k_and_s_pkg::*;

  decoded_instruction_type decoded_instruction;
  logic       zero_op;
  logic       neg_op;
  logic       unsigned_overflow;
  logic       signed_overflow;
  logic       branch;
  logic       pc_enable;
  logic       ir_enable;
  logic       addr_sel;
  logic       c_sel;
  logic [1:0] operation;
  logic       write_reg_enable;
  logic       flags_reg_enable;
  logic       ram_write_enable;
  logic       halt;

  modport master (
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

  modport slave (
    output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
           write_reg_enable, flags_reg_enable, ram_write_enable, halt
  );

endinterface

`default_nettype wire

// File: rtl/branch_eval.sv
// +--------------------------------------------------------------------+
// | branch_eval : combinational branch-taken decision from the flags    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module branch_eval
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type i_instr,
  input  logic                    i_z,
  input  logic                    i_n,
  input  logic                    i_uov,
  input  logic                    i_sov,
  output logic                    o_taken
);

  // Signed overflow is carried for future opcodes only.
  logic w_unused_sov;
  assign w_unused_sov = i_sov;

  always_comb begin
    o_taken = 1'b0;
    case (i_instr)
      I_BRANCH: o_taken = 1'b1;
      I_BZERO:  o_taken = i_z;
      I_BNZERO: o_taken = ~i_z;
      I_BNEG:   o_taken = i_n;
      I_BNNEG:  o_taken = ~i_n;
      I_BOV:    o_taken = i_uov;
      I_BNOV:   o_taken = ~i_uov;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// +--------------------------------------------------------------------+
// | control_unit : multi-cycle fetch/decode/execute FSM for K-and-S     |
// | Option macro: CONTROL_UNIT_FLAG_SHADOW_EN (latched branch flags)    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  localparam logic [CU_CNT_W-1:0] C_LAST  = CU_CNT_W'(RAM_LATENCY - 1);
  localparam logic                C_LAT_1 = (RAM_LATENCY == 1);

  cu_state_t             r_state;
  logic [CU_CNT_W-1:0]   r_cnt;
  cu_ctrl_t              r_ctrl;
  logic [CU_CNT_W-1:0]   w_cnt_inc;
  cu_state_t             w_dispatch;
  logic                  w_z, w_n, w_uov, w_sov;
  logic                  w_taken;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_dispatch = cu_dispatch(bus.decoded_instruction);

`ifdef CONTROL_UNIT_FLAG_SHADOW_EN
  logic r_z, r_n, r_uov, r_sov;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_uov <= 1'b0;
      r_sov <= 1'b0;
    end else if (r_ctrl.flags_reg_enable) begin
      r_z   <= bus.zero_op;
      r_n   <= bus.neg_op;
      r_uov <= bus.unsigned_overflow;
      r_sov <= bus.signed_overflow;
    end
  end

  assign w_z   = r_z;
  assign w_n   = r_n;
  assign w_uov = r_uov;
  assign w_sov = r_sov;
`else
  assign w_z   = bus.zero_op;
  assign w_n   = bus.neg_op;
  assign w_uov = bus.unsigned_overflow;
  assign w_sov = bus.signed_overflow;
`endif

  branch_eval u_branch_eval (
    .i_instr (bus.decoded_instruction),
    .i_z     (w_z),
    .i_n     (w_n),
    .i_uov   (w_uov),
    .i_sov   (w_sov),
    .o_taken (w_taken)
  );

  // Outputs are registered by decoding the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ctrl  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_cnt   <= '0;
          r_ctrl  <= cu_ctrl(FETCH, C_LAT_1, bus.decoded_instruction, w_taken);
        end
        FETCH: begin
          if (r_cnt == C_LAST) begin
            r_state <= DECODE;
            r_cnt   <= '0;
            r_ctrl  <= cu_ctrl(DECODE, 1'b0, bus.decoded_instruction, w_taken);
          end else begin
            r_cnt   <= w_cnt_inc;
            r_ctrl  <= cu_ctrl(FETCH, w_cnt_inc == C_LAST, bus.decoded_instruction, w_taken);
          end
        end
        DECODE: begin
          r_state <= w_dispatch;
          r_cnt   <= '0;
          r_ctrl  <= cu_ctrl(w_dispatch, C_LAT_1, bus.decoded_instruction, w_taken);
        end
        LOAD: begin
          if (r_cnt == C_LAST) begin
            r_state <= FETCH;
            r_cnt   <= '0;
            r_ctrl  <= cu_ctrl(FETCH, C_LAT_1, bus.decoded_instruction, w_taken);
          end else begin
            r_cnt   <= w_cnt_inc;
            r_ctrl  <= cu_ctrl(LOAD, w_cnt_inc == C_LAST, bus.decoded_instruction, w_taken);
          end
        end
        STORE, ALU, BRANCH, NOP: begin
          r_state <= FETCH;
          r_cnt   <= '0;
          r_ctrl  <= cu_ctrl(FETCH, C_LAT_1, bus.decoded_instruction, w_taken);
        end
        HALT: begin
          r_state <= HALT;
          r_ctrl  <= cu_ctrl(HALT, 1'b0, bus.decoded_instruction, w_taken);
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ctrl  <= '0;
        end
      endcase
    end
  end

  assign bus.branch           = r_ctrl.branch;
  assign bus.pc_enable        = r_ctrl.pc_enable;
  assign bus.ir_enable        = r_ctrl.ir_enable;
  assign bus.addr_sel         = r_ctrl.addr_sel;
  assign bus.c_sel            = r_ctrl.c_sel;
  assign bus.operation        = r_ctrl.operation;
  assign bus.write_reg_enable = r_ctrl.write_reg_enable;
  assign bus.flags_reg_enable = r_ctrl.flags_reg_enable;
  assign bus.ram_write_enable = r_ctrl.ram_write_enable;
  assign bus.halt             = r_ctrl.halt;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// +--------------------------------------------------------------------+
// | tb_control_unit : directed vector bench, RAM_LATENCY 1 and 3 DUTs   |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_control_unit;
  import k_and_s_pkg::*;

  // Bit order: branch pc ir addr csel op[1:0] wre fre rwe halt
  localparam logic [10:0] E_ZERO  = 11'b0_0_0_0_0_00_0_0_0_0;
  localparam logic [10:0] E_IR    = 11'b0_0_1_0_0_00_0_0_0_0;
  localparam logic [10:0] E_ADD   = 11'b0_1_0_0_1_01_1_1_0_0;
  localparam logic [10:0] E_SUB   = 11'b0_1_0_0_1_10_1_1_0_0;
  localparam logic [10:0] E_AND   = 11'b0_1_0_0_1_11_1_1_0_0;
  localparam logic [10:0] E_OR    = 11'b0_1_0_0_1_00_1_1_0_0;
  localparam logic [10:0] E_MOVE  = 11'b0_1_0_0_1_00_1_0_0_0;
  localparam logic [10:0] E_LOADL = 11'b0_1_0_1_0_00_1_0_0_0;
  localparam logic [10:0] E_LOADW = 11'b0_0_0_1_0_00_0_0_0_0;
  localparam logic [10:0] E_STORE = 11'b0_1_0_1_0_00_0_0_1_0;
  localparam logic [10:0] E_PC    = 11'b0_1_0_0_0_00_0_0_0_0;
  localparam logic [10:0] E_TAKEN = 11'b1_1_0_0_0_00_0_0_0_0;
  localparam logic [10:0] E_HALT  = 11'b0_0_0_0_0_00_0_0_0_1;

  typedef struct {
    decoded_instruction_type instr;
    logic                    z, n, uov;
    logic [10:0]             exp;
    string                   name;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  vec_t vecs[$];

  control_unit_if bus1();
  control_unit_if bus3();

  control_unit #(.RAM_LATENCY(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  control_unit #(.RAM_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [10:0] ctl(input int which);
    if (which == 1)
      return {bus1.branch, bus1.pc_enable, bus1.ir_enable, bus1.addr_sel, bus1.c_sel,
              bus1.operation, bus1.write_reg_enable, bus1.flags_reg_enable,
              bus1.ram_write_enable, bus1.halt};
    return {bus3.branch, bus3.pc_enable, bus3.ir_enable, bus3.addr_sel, bus3.c_sel,
            bus3.operation, bus3.write_reg_enable, bus3.flags_reg_enable,
            bus3.ram_write_enable, bus3.halt};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_ir(input int which, input string name);
    for (int i = 0; i < 20 && ctl(which) !== E_IR; i++) @(negedge clk);
    if (ctl(which) !== E_IR) begin
      n_err++;
      $display("FAIL %s: no fetch ir_enable within 20 cycles, got %b", name, ctl(which));
    end
  endtask

  task automatic addv(input decoded_instruction_type i, input logic z, input logic n,
                      input logic u, input logic [10:0] e, input string nm);
    vec_t v;
    v.instr = i; v.z = z; v.n = n; v.uov = u; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive an instruction at the IR load cycle, then check DECODE and execute.
  task automatic apply(input decoded_instruction_type i, input logic z, input logic n,
                       input logic u, input logic [10:0] e, input string nm);
    wait_ir(1, {nm, "_fetch"});
    bus1.decoded_instruction = i;
    bus1.zero_op = z; bus1.neg_op = n; bus1.unsigned_overflow = u;
    @(negedge clk);
    check({nm, "_decode"}, ctl(1), E_ZERO);
    @(negedge clk);
    check({nm, "_exec"}, ctl(1), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    rst1 = 1'b1; rst3 = 1'b1;
    bus1.decoded_instruction = I_NOP; bus3.decoded_instruction = I_NOP;
    bus1.zero_op = 0; bus1.neg_op = 0; bus1.unsigned_overflow = 0; bus1.signed_overflow = 0;
    bus3.zero_op = 0; bus3.neg_op = 0; bus3.unsigned_overflow = 0; bus3.signed_overflow = 0;

    addv(I_ADD,    0, 0, 0, E_ADD,   "add");
    addv(I_SUB,    0, 0, 0, E_SUB,   "sub");
    addv(I_AND,    0, 0, 0, E_AND,   "and");
    addv(I_OR,     0, 0, 0, E_OR,    "or");
    addv(I_MOVE,   0, 0, 0, E_MOVE,  "move");
    addv(I_LOAD,   0, 0, 0, E_LOADL, "load1");
    addv(I_STORE,  0, 0, 0, E_STORE, "store");
    addv(I_NOP,    0, 0, 0, E_PC,    "nop");
    addv(I_BRANCH, 0, 0, 0, E_TAKEN, "br");
    addv(I_BZERO,  1, 0, 0, E_TAKEN, "bz_t");
    addv(I_BZERO,  0, 0, 0, E_PC,    "bz_n");
    addv(I_BNZERO, 0, 0, 0, E_TAKEN, "bnz_t");
    addv(I_BNZERO, 1, 0, 0, E_PC,    "bnz_n");
    addv(I_BNEG,   0, 1, 0, E_TAKEN, "bneg_t");
    addv(I_BNEG,   0, 0, 0, E_PC,    "bneg_n");
    addv(I_BNNEG,  0, 1, 0, E_PC,    "bnneg_n");
    addv(I_BNNEG,  0, 0, 0, E_TAKEN, "bnneg_t");
    addv(I_BOV,    0, 0, 1, E_TAKEN, "bov_t");
    addv(I_BOV,    0, 0, 0, E_PC,    "bov_n");
    addv(I_BNOV,   0, 0, 1, E_PC,    "bnov_n");
    addv(I_BNOV,   0, 0, 0, E_TAKEN, "bnov_t");

    // Reset for two cycles, then release: IDLE, then FETCH with ir_enable.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dut1", ctl(1), E_ZERO);
    check("rst_dut3", ctl(3), E_ZERO);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rel_ir_dut1", ctl(1), E_IR);
    check("rel_f0_dut3", ctl(3), E_ZERO);
    @(negedge clk);
    check("rel_f1_dut3", ctl(3), E_ZERO);
    @(negedge clk);
    check("rel_f2_dut3", ctl(3), E_IR);

    // Branches are preceded by an ALU op carrying the same flags so both flag modes agree.
    foreach (vecs[k]) begin
      if (vecs[k].instr inside {I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO})
        apply(I_ADD, vecs[k].z, vecs[k].n, vecs[k].uov, E_ADD, {vecs[k].name, "_pre"});
      apply(vecs[k].instr, vecs[k].z, vecs[k].n, vecs[k].uov, vecs[k].exp, vecs[k].name);
    end

    apply(I_ADD, 1, 0, 0, E_ADD, "shadow_add");
`ifdef CONTROL_UNIT_FLAG_SHADOW_EN
    apply(I_BZERO, 0, 0, 0, E_TAKEN, "shadow_bz");
`else
    apply(I_BZERO, 0, 0, 0, E_PC, "shadow_bz");
`endif

    // LOAD on the RAM_LATENCY=3 core.
    wait_ir(3, "ld3_fetch");
    t0 = cyc;
    bus3.decoded_instruction = I_LOAD;
    @(negedge clk); check("ld3_decode", ctl(3), E_ZERO);
    @(negedge clk); check("ld3_c1", ctl(3), E_LOADW);
    @(negedge clk); check("ld3_c2", ctl(3), E_LOADW);
    @(negedge clk); check("ld3_c3", ctl(3), E_LOADL);
    bus3.decoded_instruction = I_NOP;
    @(negedge clk);
    wait_ir(3, "ld3_refetch");
    n_vec++;
    if (cyc - t0 != 7) begin
      n_err++;
      $display("FAIL ld3_spacing: got %0d cycles expected 7", cyc - t0);
    end

    // Reset during the LOAD wait aborts without a register write.
    wait_ir(3, "midrst_fetch");
    bus3.decoded_instruction = I_LOAD;
    @(negedge clk); check("midrst_decode", ctl(3), E_ZERO);
    @(negedge clk); check("midrst_c1", ctl(3), E_LOADW);
    rst3 = 1'b1;
    bus3.decoded_instruction = I_NOP;
    @(negedge clk); check("midrst_idle", ctl(3), E_ZERO);
    rst3 = 1'b0;
    @(negedge clk); check("midrst_f0", ctl(3), E_ZERO);
    @(negedge clk); check("midrst_f1", ctl(3), E_ZERO);
    @(negedge clk); check("midrst_f2", ctl(3), E_IR);

    // HALT is sticky until reset.
    apply(I_HALT, 0, 0, 0, E_HALT, "halt");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt_hold%0d", i), ctl(1), E_HALT);
    end
    bus1.decoded_instruction = I_NOP;
    rst1 = 1'b1;
    @(negedge clk); check("halt_rst", ctl(1), E_ZERO);
    rst1 = 1'b0;
    @(negedge clk); check("halt_refetch", ctl(1), E_IR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
